// File: rtl/hb_wt_join_pkg.sv
// Shared definitions for the two-digit BCD key-entry joiner.
// Holds the FSM state encoding, the digit and limit constants, and the
// shift-add tens/ones combiner used by the top module.
package hb_wt_join_pkg;

  // FSM state encoding (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT_B = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;

  // Largest legal BCD digit
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  // Typical LIMIT settings: minutes/seconds and hours
  localparam logic [5:0] LIMIT_MS = 6'd59;
  localparam logic [5:0] LIMIT_HR = 6'd23;

  // tens*10 + ones as (tens<<3)+(tens<<1)+ones at 7-bit width.
  // The widest legal result is 99, so 7 bits never overflow.
  function automatic logic [6:0] bcd_join(input logic [3:0] tens,
                                          input logic [3:0] ones);
    logic [6:0] t;
    logic [6:0] o;
    t = {3'b000, tens};
    o = {3'b000, ones};
    return (t << 3) + (t << 1) + o;
  endfunction

endpackage

// File: rtl/hb_wt_join_if.sv
// Bundle of key-entry and result signals for hb_wt_join.
// master: the keypad/controller side (drives key_valid, key_digit, clear, limit).
// slave : the joiner (drives number, num_valid, err, dig_a, dig_b, busy).
interface hb_wt_join_if;

  logic       key_valid;
  logic [3:0] key_digit;
  logic       clear;
  logic [5:0] limit;
  logic [5:0] number;
  logic       num_valid;
  logic       err;
  logic [3:0] dig_a;
  logic [3:0] dig_b;
  logic       busy;

  modport master (
    output key_valid, key_digit, clear, limit,
    input  number, num_valid, err, dig_a, dig_b, busy
  );

  modport slave (
    input  key_valid, key_digit, clear, limit,
    output number, num_valid, err, dig_a, dig_b, busy
  );

endinterface

// File: rtl/hb_wt_join.sv
// Joins a tens digit and a ones digit from a keypad into a 6-bit binary value,
// range-checked against a run-time limit; result or error one edge after the
// second key.
// Ports: clk, rst (async active-high), bus (hb_wt_join_if.slave): key_valid /
// key_digit / clear / limit in; number / num_valid / err / dig_a / dig_b / busy out.
module hb_wt_join
  import hb_wt_join_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic           clk,
  input  logic           rst,
  hb_wt_join_if.slave    bus
);

  // Counter only needs to reach TIMEOUT_CYC-1
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [5:0]    number;
  logic          num_valid;
  logic          err;
  logic [3:0]    dig_a;
  logic [3:0]    dig_b;
  logic [6:0]    value;
  logic          digit_ok;

  assign digit_ok = (bus.key_digit <= MAX_DIGIT);
  assign value    = bcd_join(dig_a, dig_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      number    <= '0;
      num_valid <= 1'b0;
      err       <= 1'b0;
      dig_a     <= '0;
      dig_b     <= '0;
    end else begin
      // Pulses are single-cycle; only the branches below raise them
      num_valid <= 1'b0;
      err       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.clear) begin
            dig_a <= '0;
            dig_b <= '0;
          end else if (bus.key_valid) begin
            if (digit_ok) begin
              dig_a <= bus.key_digit;
              dig_b <= '0;
              cnt   <= '0;
              state <= ST_WAIT_B;
            end else begin
              err   <= 1'b1;
              dig_a <= '0;
              dig_b <= '0;
            end
          end
        end

        ST_WAIT_B: begin
          if (bus.clear) begin
            dig_a <= '0;
            dig_b <= '0;
            state <= ST_IDLE;
          end else if (bus.key_valid) begin
            if (digit_ok) begin
              dig_b <= bus.key_digit;
              state <= ST_CHECK;
            end else begin
              err   <= 1'b1;
              dig_a <= '0;
              dig_b <= '0;
              state <= ST_IDLE;
            end
          end else if (cnt == CNT_LAST) begin
            // Ones digit never arrived: abandon the entry
            err   <= 1'b1;
            dig_a <= '0;
            dig_b <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_CHECK: begin
          // Keys arriving here are dropped; clear still wins
          if (bus.clear) begin
            dig_a <= '0;
            dig_b <= '0;
          end else if (value <= {1'b0, bus.limit}) begin
            number    <= value[5:0];
            num_valid <= 1'b1;
          end else begin
            err   <= 1'b1;
            dig_a <= '0;
            dig_b <= '0;
          end
          state <= ST_IDLE;
        end

        default: begin
          dig_a <= '0;
          dig_b <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.number    = number;
  assign bus.num_valid = num_valid;
  assign bus.err       = err;
  assign bus.dig_a     = dig_a;
  assign bus.dig_b     = dig_b;
  assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_hb_wt_join.sv
// Directed bench for hb_wt_join with a short timeout (TIMEOUT_CYC=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_hb_wt_join;
  import hb_wt_join_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  hb_wt_join_if ifc ();

  hb_wt_join #(.TIMEOUT_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    ifc.key_valid = 1'b1;
    ifc.key_digit = d;
    tick();
    ifc.key_valid = 1'b0;
    ifc.key_digit = 4'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int err_seen;
    ifc.key_valid = 1'b0;
    ifc.key_digit = 4'd0;
    ifc.clear     = 1'b0;
    ifc.limit     = LIMIT_MS;

    // Reset state
    tick();
    tick();
    check("rst_number", ifc.number, 0);
    check("rst_numvld", ifc.num_valid, 0);
    check("rst_err", ifc.err, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_dig_a", ifc.dig_a, 0);
    check("rst_dig_b", ifc.dig_b, 0);
    rst = 1'b0;
    tick();

    // 4,7 with limit 59 -> 47
    key(4'd4);
    check("k4_busy", ifc.busy, 1);
    check("k4_dig_a", ifc.dig_a, 4);
    check("k4_dig_b", ifc.dig_b, 0);
    key(4'd7);
    check("k7_numvld_early", ifc.num_valid, 0);
    check("k7_dig_b", ifc.dig_b, 7);
    tick();
    check("47_numvld", ifc.num_valid, 1);
    check("47_number", ifc.number, 47);
    check("47_busy", ifc.busy, 0);
    tick();
    check("47_numvld_drop", ifc.num_valid, 0);

    // Hour limit: 25 rejected, 23 accepted
    ifc.limit = LIMIT_HR;
    key(4'd2);
    key(4'd5);
    tick();
    check("25_err", ifc.err, 1);
    check("25_numvld", ifc.num_valid, 0);
    check("25_number_held", ifc.number, 47);
    check("25_dig_a", ifc.dig_a, 0);
    tick();
    check("25_err_drop", ifc.err, 0);
    key(4'd2);
    key(4'd3);
    tick();
    check("23_numvld", ifc.num_valid, 1);
    check("23_number", ifc.number, 23);

    // Timeout after first digit
    tick();
    key(4'd3);
    check("to_dig_a", ifc.dig_a, 3);
    err_seen = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (ifc.err) err_seen++;
    end
    check("to_no_early_err", err_seen, 0);
    check("to_still_busy", ifc.busy, 1);
    tick();
    check("to_err", ifc.err, 1);
    check("to_dig_a_clr", ifc.dig_a, 0);
    check("to_idle", ifc.busy, 0);
    tick();

    // Illegal digit in IDLE and in WAIT_B; key in CHECK ignored
    ifc.limit = LIMIT_MS;
    key(4'd11);
    check("ill_idle_err", ifc.err, 1);
    check("ill_idle_busy", ifc.busy, 0);
    tick();
    key(4'd1);
    key(4'd11);
    check("ill_wb_err", ifc.err, 1);
    check("ill_wb_numvld", ifc.num_valid, 0);
    check("ill_wb_dig_a", ifc.dig_a, 0);
    check("ill_wb_busy", ifc.busy, 0);
    key(4'd1);
    key(4'd2);
    key(4'd5);
    check("chk_key_numvld", ifc.num_valid, 1);
    check("chk_key_number", ifc.number, 12);
    check("chk_key_err", ifc.err, 0);
    check("chk_key_busy", ifc.busy, 0);

    // Clear with the second key
    key(4'd1);
    ifc.clear     = 1'b1;
    ifc.key_valid = 1'b1;
    ifc.key_digit = 4'd2;
    tick();
    ifc.clear     = 1'b0;
    ifc.key_valid = 1'b0;
    check("clr_busy", ifc.busy, 0);
    check("clr_dig_a", ifc.dig_a, 0);
    check("clr_err", ifc.err, 0);
    tick();
    check("clr_numvld", ifc.num_valid, 0);
    check("clr_number", ifc.number, 12);

    // Reset during WAIT_B: outputs drop without a clock edge
    key(4'd6);
    check("rwb_busy_pre", ifc.busy, 1);
    rst = 1'b1;
    #1;
    check("rwb_number", ifc.number, 0);
    check("rwb_busy", ifc.busy, 0);
    check("rwb_dig_a", ifc.dig_a, 0);
    tick();
    rst = 1'b0;
    err_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifc.err || ifc.num_valid || ifc.busy) err_seen++;
    end
    check("rwb_no_pulse", err_seen, 0);

    // 59 then 00
    key(4'd5);
    key(4'd9);
    tick();
    check("59_numvld", ifc.num_valid, 1);
    check("59_number", ifc.number, 59);
    key(4'd0);
    key(4'd0);
    tick();
    check("00_numvld", ifc.num_valid, 1);
    check("00_number", ifc.number, 0);
    check("00_err", ifc.err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hb_wt_join.md
HB_WT_JOIN -- requirements
Module: hb_wt_join

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000; CLK cycles allowed between the tens digit and the ones digit.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 KEY_VALID  input  1  one-cycle strobe; KEY_DIGIT is valid in this cycle.
REQ-005 KEY_DIGIT  input  4  entered BCD digit, legal range 0-9.
REQ-006 CLEAR  input  1  abandon the entry in progress.
REQ-007 LIMIT  input  6  maximum accepted value (59 for minute/second, 23 for hour), sampled in CHECK.
REQ-008 NUMBER  output  6  last accepted binary value.
REQ-009 NUM_VALID  output  1  one-cycle pulse when NUMBER is updated.
REQ-010 ERR  output  1  one-cycle pulse when an entry is rejected.
REQ-011 DIG_A, DIG_B  output  4 each  captured tens and ones digits, for display echo.
REQ-012 BUSY  output  1  high while the state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, WAIT_B and CHECK.
REQ-014 IDLE: KEY_VALID with KEY_DIGIT<=9 -> DIG_A=KEY_DIGIT, DIG_B=0, timeout counter cleared, next state WAIT_B.
REQ-015 WAIT_B: KEY_VALID with KEY_DIGIT<=9 -> DIG_B=KEY_DIGIT, next state CHECK.
REQ-016 WAIT_B: the counter increments every cycle; when it reaches TIMEOUT_CYC-1 without a key -> ERR pulse, DIG_A=DIG_B=0, next state IDLE.
REQ-017 CHECK: value = DIG_A*10+DIG_B, computed as (DIG_A<<3)+(DIG_A<<1)+DIG_B at 7-bit width; next state is always IDLE.
REQ-018 CHECK with value<=LIMIT -> NUMBER=value[5:0] and NUM_VALID=1 on the next edge.
REQ-019 CHECK with value>LIMIT -> ERR=1 on the next edge; NUMBER unchanged; DIG_A/DIG_B cleared.
REQ-020 Latency: the second key is sampled at edge N; NUMBER/NUM_VALID (or ERR) update at edge N+1.
REQ-021 KEY_VALID with KEY_DIGIT>9 in IDLE or WAIT_B -> ERR pulse, DIG_A=DIG_B=0, next state IDLE.
REQ-022 KEY_VALID in CHECK is ignored; no ERR is raised.
REQ-023 CLEAR has priority over KEY_VALID in every state: next state IDLE, DIG_A=DIG_B=0, no NUM_VALID, no ERR.
REQ-024 NUM_VALID and ERR are mutually exclusive and each is high for exactly one cycle.
REQ-025 NUMBER holds its value until the next accepted entry; value 0 ("00") is a legal entry.
REQ-026 LIMIT values above 59 are not supported.

Reset
REQ-027 While RESET=1, regardless of CLK: state=IDLE, NUMBER=0, DIG_A=DIG_B=0, NUM_VALID=0, ERR=0, BUSY=0, counter=0.
REQ-028 RESET asserted mid-entry SHALL discard the partial entry; no pulse is issued after release.

Structure
REQ-029 The shared package holds the FSM state encoding, MAX_DIGIT=9, LIMIT_MS=59 and LIMIT_HR=23.
REQ-030 The block is a single module with no sub-module; the multiply-by-10 is shift-add, not a multiplier.

Verification
REQ-031 LIMIT=59; keys 4 then 7 -> NUMBER=47, NUM_VALID pulses one edge after the second key, BUSY low afterwards.
REQ-032 LIMIT=23; keys 2 then 5 -> ERR pulse, NUMBER keeps its prior value; keys 2 then 3 -> NUMBER=23.
REQ-033 TIMEOUT_CYC=8; key 3, then no key for 8 cycles -> ERR pulse, DIG_A=0, state IDLE.
REQ-034 Key 11 (illegal digit) in IDLE and in WAIT_B -> ERR pulse, no NUM_VALID; key 5 in CHECK -> ignored.
REQ-035 Key 1 with CLEAR=1 on the same cycle as a second key 2 -> no pulse, IDLE; RESET during WAIT_B -> all outputs 0 immediately.
REQ-036 LIMIT=59; keys 0 then 0 -> NUMBER=0 with NUM_VALID; keys 5 then 9 -> NUMBER=59.
